// File: rtl/spec_fifo_pkg.sv
// Shared width helpers, branch-mask type and resolve kind for the speculative FIFO controller.
package spec_fifo_pkg;

  localparam int NUM_BR_DEFAULT = 4;

  typedef logic [NUM_BR_DEFAULT-1:0] br_mask_t;

  typedef enum logic {
    RESOLVE_CORRECT    = 1'b0,
    RESOLVE_MISPREDICT = 1'b1
  } resolve_kind_e;

  function automatic int calc_pw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int calc_iw(input int num_in);
    return $clog2(num_in + 1);
  endfunction

  function automatic int calc_tw(input int num_br);
    return $clog2(num_br);
  endfunction

endpackage

// File: rtl/spec_fifo_mask_array.sv
// Per-slot valid bits and branch-dependency masks, with tag clearing, squash
// detection and the count of entries that survive a misprediction.
module spec_fifo_mask_array
  import spec_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_IN = 2,
  parameter int NUM_BR = 4,
  localparam int PW = calc_pw(DEPTH),
  localparam int CW = calc_cw(DEPTH),
  localparam int IW = calc_iw(NUM_IN),
  localparam int TW = calc_tw(NUM_BR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic [PW-1:0]     push_base,
  input  logic [IW-1:0]     push_count,
  input  logic [NUM_BR-1:0] push_mask,
  input  logic              pop_en,
  input  logic [PW-1:0]     head_idx,
  input  logic              clear_en,
  input  logic              flush,
  input  logic [TW-1:0]     resolve_tag,
  output logic [DEPTH-1:0]  entry_valid,
  output logic [NUM_BR-1:0] head_mask,
  output logic              squash_any,
  output logic [CW-1:0]     survivor_count
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [NUM_BR-1:0] mask_q [DEPTH];
  logic [NUM_BR-1:0] mask_d [DEPTH];
  logic [DEPTH-1:0]  squash_vec;
  logic [NUM_BR-1:0] clear_bit;
  logic [PW-1:0]     push_slot;

  always_comb begin
    clear_bit = '0;
    clear_bit[resolve_tag] = clear_en;
  end

  always_comb begin
    squash_vec = '0;
    for (int s = 0; s < DEPTH; s++) begin
      squash_vec[s] = flush && valid_q[s] && mask_q[s][resolve_tag];
    end
  end

  // Survivors are counted including the head, so head + survivors is the new
  // tail whether or not the head is popped in the same cycle.
  always_comb begin
    survivor_count = '0;
    for (int s = 0; s < DEPTH; s++) begin
      survivor_count = survivor_count + CW'(valid_q[s] && !squash_vec[s]);
    end
  end

  always_comb begin
    valid_d   = valid_q & ~squash_vec;
    push_slot = '0;
    for (int s = 0; s < DEPTH; s++) begin
      mask_d[s] = mask_q[s] & ~clear_bit;
    end
    if (pop_en) begin
      valid_d[head_idx] = 1'b0;
    end
    if (push_en) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (IW'(k) < push_count) begin
          push_slot          = push_base + PW'(k);
          valid_d[push_slot] = 1'b1;
          mask_d[push_slot]  = push_mask & ~clear_bit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        mask_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < DEPTH; s++) begin
        mask_q[s] <= mask_d[s];
      end
    end
  end

  assign entry_valid = valid_q;
  assign head_mask   = mask_q[head_idx];
  assign squash_any  = |squash_vec;

endmodule

// File: rtl/speculative_fifo_controller.sv
// Control-only circular FIFO with branch-tag speculation: owns head/tail pointers,
// handshakes and occupancy; slot state lives in spec_fifo_mask_array.
module speculative_fifo_controller
  import spec_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_IN = 2,
  parameter int NUM_BR = 4,
  localparam int PW = calc_pw(DEPTH),
  localparam int CW = calc_cw(DEPTH),
  localparam int IW = calc_iw(NUM_IN),
  localparam int TW = calc_tw(NUM_BR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [IW-1:0]     i_count,
  input  logic [NUM_BR-1:0] i_br_mask,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NUM_BR-1:0] o_br_mask,
  input  logic              i_resolve_valid,
  input  logic [TW-1:0]     i_resolve_tag,
  input  logic              i_resolve_mispredict,
  output logic [PW-1:0]     o_wr_ptr,
  output logic [PW-1:0]     o_rd_ptr,
  output logic [CW-1:0]     o_count,
  output logic [DEPTH-1:0]  o_entry_valid
);

  logic [CW-1:0]     head_q;
  logic [CW-1:0]     head_d;
  logic [CW-1:0]     tail_q;
  logic [CW-1:0]     tail_d;
  logic [CW-1:0]     count;
  logic [CW-1:0]     survivor_count;
  logic [NUM_BR-1:0] head_mask;
  resolve_kind_e     resolve_kind;
  logic              flush;
  logic              clear_en;
  logic              push_en;
  logic              pop_en;
  logic              squash_any;

  always_comb begin
    resolve_kind = i_resolve_mispredict ? RESOLVE_MISPREDICT : RESOLVE_CORRECT;
    flush        = i_resolve_valid && (resolve_kind == RESOLVE_MISPREDICT);
    clear_en     = i_resolve_valid && (resolve_kind == RESOLVE_CORRECT);
  end

  // Readiness looks only at current occupancy; a same-cycle pop never makes room.
  assign count   = tail_q - head_q;
  assign i_ready = (count <= CW'(DEPTH - NUM_IN)) && !flush;
  assign o_valid = (count != '0) && !(flush && head_mask[i_resolve_tag]);
  assign push_en = i_valid && i_ready;
  assign pop_en  = o_valid && o_ready;

  always_comb begin
    head_d = head_q + CW'(pop_en);
    tail_d = tail_q;
    if (flush && squash_any) begin
      tail_d = head_q + survivor_count;
    end else if (push_en) begin
      tail_d = tail_q + CW'(i_count);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  spec_fifo_mask_array #(
    .DEPTH  (DEPTH),
    .NUM_IN (NUM_IN),
    .NUM_BR (NUM_BR)
  ) u_mask_array (
    .clk            (clk),
    .rst            (rst),
    .push_en        (push_en),
    .push_base      (tail_q[PW-1:0]),
    .push_count     (i_count),
    .push_mask      (i_br_mask),
    .pop_en         (pop_en),
    .head_idx       (head_q[PW-1:0]),
    .clear_en       (clear_en),
    .flush          (flush),
    .resolve_tag    (i_resolve_tag),
    .entry_valid    (o_entry_valid),
    .head_mask      (head_mask),
    .squash_any     (squash_any),
    .survivor_count (survivor_count)
  );

  assign o_count   = count;
  assign o_wr_ptr  = tail_q[PW-1:0];
  assign o_rd_ptr  = head_q[PW-1:0];
  assign o_br_mask = head_mask;

endmodule

// File: tb/tb_speculative_fifo_controller.sv
// Directed and randomized checks of speculative_fifo_controller against a
// queue-of-masks reference model.
module tb_speculative_fifo_controller;
  import spec_fifo_pkg::*;

  localparam int DEPTH  = 8;
  localparam int NUM_IN = 2;
  localparam int NUM_BR = 4;
  localparam int PW = 3;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [IW-1:0]     i_count;
  logic [NUM_BR-1:0] i_br_mask;
  logic              o_valid;
  logic              o_ready;
  logic [NUM_BR-1:0] o_br_mask;
  logic              i_resolve_valid;
  logic [TW-1:0]     i_resolve_tag;
  logic              i_resolve_mispredict;
  logic [PW-1:0]     o_wr_ptr;
  logic [PW-1:0]     o_rd_ptr;
  logic [CW-1:0]     o_count;
  logic [DEPTH-1:0]  o_entry_valid;

  always #5 clk = ~clk;

  speculative_fifo_controller #(
    .DEPTH  (DEPTH),
    .NUM_IN (NUM_IN),
    .NUM_BR (NUM_BR)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_valid              (i_valid),
    .i_ready              (i_ready),
    .i_count              (i_count),
    .i_br_mask            (i_br_mask),
    .o_valid              (o_valid),
    .o_ready              (o_ready),
    .o_br_mask            (o_br_mask),
    .i_resolve_valid      (i_resolve_valid),
    .i_resolve_tag        (i_resolve_tag),
    .i_resolve_mispredict (i_resolve_mispredict),
    .o_wr_ptr             (o_wr_ptr),
    .o_rd_ptr             (o_rd_ptr),
    .o_count              (o_count),
    .o_entry_valid        (o_entry_valid)
  );

  // Reference model: the live entries, oldest first, and the absolute head index.
  br_mask_t model_q[$];
  int       model_head;
  int       checks = 0;
  int       errors = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic set_idle();
    i_valid              = 1'b0;
    i_count              = IW'(1);
    i_br_mask            = '0;
    o_ready              = 1'b0;
    i_resolve_valid      = 1'b0;
    i_resolve_tag        = '0;
    i_resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_head = 0;
  endtask

  function automatic logic model_head_squashed(input logic flush, input logic [TW-1:0] tag);
    if (!flush || model_q.size() == 0) return 1'b0;
    return model_q[0][tag];
  endfunction

  task automatic check_model(input logic flush, input logic [TW-1:0] tag);
    int n = model_q.size();
    logic [DEPTH-1:0] ev = '0;
    for (int i = 0; i < n; i++) ev[(model_head + i) % DEPTH] = 1'b1;
    check_output("i_ready", i_ready, (n <= DEPTH - NUM_IN) && !flush);
    check_output("o_valid", o_valid, (n != 0) && !model_head_squashed(flush, tag));
    check_output("o_count", o_count, n);
    check_output("o_rd_ptr", o_rd_ptr, model_head % DEPTH);
    check_output("o_wr_ptr", o_wr_ptr, (model_head + n) % DEPTH);
    check_output("o_entry_valid", o_entry_valid, ev);
    if (n != 0) check_output("o_br_mask", o_br_mask, model_q[0]);
  endtask

  // One cycle: drive at negedge, check, advance the model, idle inputs after the edge.
  task automatic apply_stimulus(input logic valid, input int cnt, input br_mask_t mask,
                                input logic oready, input logic rv, input int tag,
                                input logic mis);
    logic     flush, correct, push, pop;
    br_mask_t m;
    br_mask_t kept[$];
    int       n;
    @(negedge clk);
    i_valid              = valid;
    i_count              = IW'(cnt);
    i_br_mask            = mask;
    o_ready              = oready;
    i_resolve_valid      = rv;
    i_resolve_tag        = TW'(tag);
    i_resolve_mispredict = mis;
    #1;
    flush   = rv && mis;
    correct = rv && !mis;
    check_model(flush, TW'(tag));
    n    = model_q.size();
    push = valid && (n <= DEPTH - NUM_IN) && !flush;
    pop  = oready && (n != 0) && !model_head_squashed(flush, TW'(tag));
    if (pop) begin
      model_q.delete(0);
      model_head = (model_head + 1) % (2 * DEPTH);
    end
    if (flush) begin
      foreach (model_q[i]) if (!model_q[i][tag]) kept.push_back(model_q[i]);
      model_q = kept;
    end
    if (correct) begin
      foreach (model_q[i]) model_q[i] = model_q[i] & ~(br_mask_t'(1) << tag);
    end
    if (push) begin
      m = correct ? (mask & ~(br_mask_t'(1) << tag)) : mask;
      repeat (cnt) model_q.push_back(m);
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic push_entries(input int cnt, input br_mask_t mask);
    apply_stimulus(1'b1, cnt, mask, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    br_mask_t rmask;
    set_idle();
    rst = 1'b1;
    do_reset();

    #1;
    check_output("reset_o_valid", o_valid, 0);
    check_output("reset_o_count", o_count, 0);
    check_output("reset_o_wr_ptr", o_wr_ptr, 0);
    check_output("reset_o_rd_ptr", o_rd_ptr, 0);
    check_output("reset_o_br_mask", o_br_mask, 0);
    check_output("reset_i_ready", i_ready, 1);
    check_output("reset_o_entry_valid", o_entry_valid, 0);

    $display("[TB] two pushes of two, then fill to seven");
    push_entries(2, 4'b0000);
    push_entries(2, 4'b0000);
    check_output("fill4_o_count", o_count, 4);
    check_output("fill4_o_wr_ptr", o_wr_ptr, 4);
    check_output("fill4_o_entry_valid", o_entry_valid, 8'h0F);
    check_output("fill4_i_ready", i_ready, 1);
    push_entries(2, 4'b0000);
    push_entries(1, 4'b0000);
    check_output("fill7_o_count", o_count, 7);
    check_output("fill7_i_ready", i_ready, 0);
    apply_stimulus(1'b1, 1, 4'b0000, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] pointer wrap from head 6");
    do_reset();
    repeat (3) push_entries(2, 4'b0000);
    repeat (6) apply_stimulus(1'b0, 1, 4'b0000, 1'b1, 1'b0, 0, 1'b0);
    repeat (4) push_entries(2, 4'b0000);
    check_output("full_o_count", o_count, 8);
    check_output("full_o_rd_ptr", o_rd_ptr, 6);
    check_output("full_o_wr_ptr", o_wr_ptr, 6);
    repeat (8) apply_stimulus(1'b1, 1, 4'b0000, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] mispredict squashes younger suffix");
    do_reset();
    push_entries(2, 4'b0000);
    push_entries(1, 4'b0000);
    push_entries(2, 4'b0010);
    push_entries(1, 4'b0010);
    apply_stimulus(1'b1, 1, 4'b0010, 1'b0, 1'b1, 1, 1'b1);
    check_output("squash_o_count", o_count, 3);
    check_output("squash_o_wr_ptr", o_wr_ptr, 3);
    check_output("squash_o_entry_valid", o_entry_valid, 8'h07);

    $display("[TB] correct resolve clears tag");
    do_reset();
    push_entries(2, 4'b0000);
    push_entries(1, 4'b0000);
    push_entries(2, 4'b0010);
    push_entries(1, 4'b0010);
    apply_stimulus(1'b0, 1, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
    check_output("clear_o_count", o_count, 6);
    apply_stimulus(1'b0, 1, 4'b0000, 1'b0, 1'b1, 1, 1'b1);
    check_output("clear_then_mis_o_count", o_count, 6);
    repeat (6) apply_stimulus(1'b0, 1, 4'b0000, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] squashed head is not popped");
    do_reset();
    push_entries(1, 4'b0100);
    apply_stimulus(1'b0, 1, 4'b0000, 1'b1, 1'b1, 2, 1'b1);
    check_output("headsquash_o_count", o_count, 0);
    check_output("headsquash_o_rd_ptr", o_rd_ptr, 0);
    check_output("headsquash_o_valid", o_valid, 0);

    $display("[TB] asynchronous reset mid-burst");
    do_reset();
    push_entries(2, 4'b0000);
    push_entries(2, 4'b0000);
    push_entries(1, 4'b0000);
    check_output("preburst_o_count", o_count, 5);
    @(negedge clk);
    i_valid = 1'b1;
    i_count = IW'(1);
    o_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_output("async_o_count", o_count, 0);
    check_output("async_o_valid", o_valid, 0);
    check_output("async_o_wr_ptr", o_wr_ptr, 0);
    check_output("async_o_rd_ptr", o_rd_ptr, 0);
    check_output("async_o_entry_valid", o_entry_valid, 0);
    check_output("async_o_br_mask", o_br_mask, 0);
    check_output("async_i_ready", i_ready, 1);
    do_reset();

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 600; cyc++) begin
      rmask = (model_q.size() != 0) ? model_q[model_q.size() - 1] : br_mask_t'(0);
      if ($urandom_range(0, 3) == 0) rmask = rmask | (br_mask_t'(1) << $urandom_range(0, NUM_BR - 1));
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(1, NUM_IN), rmask,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                     $urandom_range(0, NUM_BR - 1), $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speculative_fifo_controller.md
# speculative_fifo_controller

Control-only circular FIFO for age-ordered instruction queues. It accepts up to NUM_IN entries per cycle and retires one per cycle. Each entry carries a branch-dependency mask over NUM_BR outstanding branch tags. On a correct prediction it clears the tag; on a misprediction it squashes every dependent entry in the same cycle. Data storage lives in the instantiating queue, which writes and reads its payload RAM using the pointers produced here.

## Interface
- DEPTH, 8: entry count; power of two, ≥ 4, ≥ NUM_IN.
- NUM_IN, 2: max entries pushed per cycle, ≥ 1.
- NUM_BR, 4: number of branch tags, ≥ 2.
- Derived: PW = $clog2(DEPTH), CW = $clog2(DEPTH)+1, IW = $clog2(NUM_IN+1), TW = $clog2(NUM_BR).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  push request.
- i_ready  out  1  push accepted when i_valid && i_ready.
- i_count  in  IW  entries in this push; 1..NUM_IN. 0 with i_valid is illegal.
- i_br_mask  in  NUM_BR  tags the pushed entries depend on.
- o_valid  out  1  head entry available.
- o_ready  in  1  pop one head entry.
- o_br_mask  out  NUM_BR  stored mask of the head entry.
- i_resolve_valid  in  1  a branch resolves this cycle.
- i_resolve_tag  in  TW  tag being resolved.
- i_resolve_mispredict  in  1  1 = squash dependents, 0 = clear the tag.
- o_wr_ptr  out  PW  slot for the first pushed entry; entry k goes to (o_wr_ptr+k) mod DEPTH.
- o_rd_ptr  out  PW  head slot.
- o_count  out  CW  occupancy.
- o_entry_valid  out  DEPTH  per-slot valid.

## Operation
- State:
  - head and tail pointers, each PW+1 bits with a wrap bit;
  - per-slot valid bit;
  - per-slot NUM_BR mask.
- Derived values:
  - o_count = tail − head, computed in CW bits.
  - o_wr_ptr = tail[PW-1:0].
  - o_rd_ptr = head[PW-1:0].
- flush = i_resolve_valid && i_resolve_mispredict.
- i_ready = (o_count ≤ DEPTH−NUM_IN) && !flush. Readiness depends only on current occupancy; a same-cycle pop does not free space for a push.
- Push:
  - Slots tail..tail+i_count−1 (mod DEPTH) become valid.
  - Their mask = i_br_mask with bit i_resolve_tag cleared when a correct resolve occurs in the same cycle.
  - tail += i_count.
- Pop: when o_valid && o_ready, the head slot is invalidated and head += 1.
- Correct resolve: clears bit i_resolve_tag in every slot's mask.
- Mispredict:
  - Every valid slot whose mask has bit i_resolve_tag set is invalidated.
  - tail moves to the oldest squashed slot; it is unchanged if nothing is squashed.
  - Upstream guarantees that younger entries carry a superset of older entries' tags, so the squashed set is always a contiguous tail suffix. Compute the new tail as head + (number of unsquashed valid entries).
- o_valid = (o_count ≠ 0) && !(flush && o_br_mask[i_resolve_tag]). A squashed head is never popped.
- Pop with a non-squashed head during a mispredict is legal; the new tail computation accounts for it.

## Timing
- Reset: head = tail = 0, all valid = 0, all masks = 0. After reset, o_valid = 0, o_count = 0, o_wr_ptr = o_rd_ptr = 0, o_br_mask = 0, and i_ready = 1.
- Latency:
  - A pushed entry is visible at o_valid / o_entry_valid on the next cycle; no bypass.
  - Mask clearing and squashing take effect on the next cycle.
  - i_ready and o_valid deassert combinationally in the flush cycle.
- Wrap-around: pointers increment modulo 2·DEPTH. Full is o_count = DEPTH; empty is o_count = 0.
- Simultaneous push, pop and correct resolve: all three apply in the same cycle.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- A resolve for a tag that no entry holds is a no-op.

## Structure
- Package spec_fifo_pkg holds:
  - the derived-width functions (PW, CW, IW, TW);
  - a typedef for the branch mask;
  - the enum for resolve kind (RESOLVE_CORRECT, RESOLVE_MISPREDICT).
- Sub-module spec_fifo_mask_array holds:
  - the per-slot valid and mask registers;
  - the clear-bit, squash-vector and survivor-count logic.
- The top level holds the pointers, handshake and o_count.

## Test plan
- Reset, then push i_count=2 twice with DEPTH=8 → o_count=4, o_wr_ptr=4, o_entry_valid=8'h0F, i_ready=1. At o_count=7, i_ready=0 even with o_ready=1.
- Fill to 8, then pop 8 times while pushing i_count=1 each cycle from head=6 → pointers wrap 7→0, o_count stays correct, o_rd_ptr=6,7,0,1…
- Push 3 entries with mask 4'b0000, then 3 with 4'b0010; mispredict tag 1 → next cycle o_count=3, o_wr_ptr=3, o_entry_valid=8'h07; i_ready=0 during the flush cycle.
- Same fill, correct resolve of tag 1 → o_count=6, all masks 0; a later mispredict on tag 1 squashes nothing.
- Head mask 4'b0100, mispredict tag 2 with o_ready=1 → o_valid=0 in that cycle, queue empty on the next cycle, head unchanged.
- Assert rst mid-burst with o_count=5 → all outputs return to reset values before the next clk edge.
